// File: rtl/nanci_edge_collector.sv
// East-edge PE word collector: captures DEPTH words into an address-indexed buffer, then drains them in address order.
// Optional macro NANCI_COLLECT_SKIP_EMPTY_EN: drain skips addresses never captured instead of emitting them as zero.
module nanci_edge_collector #(
   parameter int ADDR_WIDTH    = 3,
   parameter int DATA_WIDTH    = 3,
   parameter int DEPTH         = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
   output logic [ADDR_WIDTH-1:0]          o_addr,
   output logic [DATA_WIDTH-1:0]          o_data,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic                           busy,
   output logic                           done,
   output logic [1:0]                     dbg_state
);

   localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   // Handshake: an entry moves when o_valid && i_ready at a rising edge; o_addr/o_data
   // hold while o_valid && !i_ready, and o_valid never drops before acceptance.
   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [SW-1:0]         settle_cnt;
   logic [ADDR_WIDTH-1:0] cap_cnt;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH-1:0] ptr_inc;
   logic [DATA_WIDTH-1:0] buf_mem [DEPTH];
   logic [DEPTH-1:0]      present;
   logic [ADDR_WIDTH-1:0] pe_addr;
   logic [DATA_WIDTH-1:0] pe_data;
   logic [DATA_WIDTH-1:0] cur_data, next_data;
   logic                  emit_cur, emit_next;
   logic                  handshake, last_ptr, cap_last, drain_finish;

   assign pe_addr   = i_PE[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
   assign pe_data   = i_PE[DATA_WIDTH-1:0];
   assign ptr_inc   = ptr + 1'b1;
   assign handshake = o_valid && i_ready;
   assign last_ptr  = (ptr == ADDR_WIDTH'(DEPTH - 1));
   assign cap_last  = (cap_cnt == ADDR_WIDTH'(DEPTH - 1));
   assign cur_data  = present[ptr] ? buf_mem[ptr] : '0;
   assign next_data = present[ptr_inc] ? buf_mem[ptr_inc] : '0;

`ifdef NANCI_COLLECT_SKIP_EMPTY_EN
   assign emit_cur  = present[ptr];
   assign emit_next = present[ptr_inc];
`else
   assign emit_cur  = 1'b1;
   assign emit_next = 1'b1;
`endif

   // Drain ends on acceptance of the last slot, or when the scan reaches it with nothing to emit.
   assign drain_finish = (state == DRAIN) && last_ptr && (handshake || (!o_valid && !emit_cur));

   assign busy      = (state != IDLE);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
         SETTLE:  if (settle_cnt == SW'(1)) state_nxt = CAPTURE;
         CAPTURE: if (cap_last) state_nxt = DRAIN;
         DRAIN:   if (drain_finish) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Buffer contents are don't-care after reset; only the present bits are cleared.
   always_ff @(posedge clk) begin
      if (!rst && state == CAPTURE) buf_mem[pe_addr] <= pe_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         present    <= '0;
         settle_cnt <= '0;
         cap_cnt    <= '0;
         ptr        <= '0;
         o_addr     <= '0;
         o_data     <= '0;
         o_valid    <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  present    <= '0;
                  settle_cnt <= SW'(SETTLE_CYCLES);
                  cap_cnt    <= '0;
               end
            end
            SETTLE: settle_cnt <= settle_cnt - 1'b1;
            CAPTURE: begin
               present[pe_addr] <= 1'b1;
               cap_cnt          <= cap_cnt + 1'b1;
               if (cap_last) ptr <= '0;
            end
            DRAIN: begin
               if (o_valid) begin
                  if (handshake) begin
                     if (last_ptr) begin
                        o_valid <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        ptr     <= ptr_inc;
                        o_addr  <= ptr_inc;
                        o_data  <= next_data;
                        o_valid <= emit_next;
                     end
                  end
               end else if (emit_cur) begin
                  // First slot after capture (or next present slot) is loaded one cycle late
                  // so the final captured word is visible in the buffer.
                  o_valid <= 1'b1;
                  o_addr  <= ptr;
                  o_data  <= cur_data;
               end else if (last_ptr) begin
                  done <= 1'b1;
               end else begin
                  ptr <= ptr_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nanci_edge_collector.sv
// Randomized and directed bench for nanci_edge_collector; expected beats come from an address-map model of each capture.
module tb_nanci_edge_collector;

   localparam int AW     = 3;
   localparam int DW     = 3;
   localparam int DEPTH  = 8;
   localparam int SETTLE = 1;
   localparam int WW     = AW + DW;

   logic          clk = 1'b0;
   logic          rst, start, i_ready;
   logic [WW-1:0] i_PE;
   logic [AW-1:0] o_addr;
   logic [DW-1:0] o_data;
   logic          o_valid, busy, done;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_fails  = 0;

   logic [WW-1:0] exp_q[$];
   logic [WW-1:0] words [DEPTH];

   nanci_edge_collector #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .i_PE(i_PE),
      .o_addr(o_addr), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: last write per address wins; the drain walks addresses 0..DEPTH-1.
   task automatic build_model();
      logic [DW-1:0] mdata [DEPTH];
      bit            mpres [DEPTH];
      for (int a = 0; a < DEPTH; a++) begin mdata[a] = '0; mpres[a] = 0; end
      for (int i = 0; i < DEPTH; i++) begin
         mdata[words[i][WW-1:DW]] = words[i][DW-1:0];
         mpres[words[i][WW-1:DW]] = 1;
      end
      exp_q.delete();
      for (int a = 0; a < DEPTH; a++) begin
`ifdef NANCI_COLLECT_SKIP_EMPTY_EN
         if (mpres[a]) exp_q.push_back({AW'(a), mdata[a]});
`else
         exp_q.push_back({AW'(a), mpres[a] ? mdata[a] : DW'(0)});
`endif
      end
   endtask

   // ready_mode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
   task automatic run_test(input int ready_mode, input int abort_after, input bit stray_start);
      int            lat, beats, dones, cyc, n_exp;
      bit            stalled, first_seen, ready_now;
      logic [AW-1:0] held_a;
      logic [DW-1:0] held_d;
      logic [WW-1:0] e;
      bit            first_is_zero;
      build_model();
      n_exp = exp_q.size();
      first_is_zero = (n_exp > 0) && (exp_q[0][WW-1:DW] == '0);
      @(negedge clk);
      start   = 1'b1;
      i_ready = 1'b0;
      lat = -1;
      for (int c = 0; c < SETTLE + DEPTH; c++) begin
         @(negedge clk);
         lat++;
         start = stray_start && (c == SETTLE + 2);
         i_PE  = (c < SETTLE) ? WW'($urandom) : words[c - SETTLE];
         if (c == SETTLE) check("busy_capture", busy, 1);
         if (c == SETTLE + DEPTH - 1) check("valid_low_capture", o_valid, 0);
      end
      beats = 0; dones = 0; cyc = 0; stalled = 0; first_seen = 0;
      held_a = '0; held_d = '0;
      forever begin
         @(negedge clk);
         lat++;
         cyc++;
         start = stray_start && (lat == 12);
         if (o_valid && !first_seen) begin
            first_seen = 1;
            if (first_is_zero) check("first_valid_latency", lat, 1 + SETTLE + DEPTH);
         end
         if (stalled) begin
            check("hold_valid", o_valid, 1);
            check("hold_addr", o_addr, held_a);
            check("hold_data", o_data, held_d);
         end
         if (done) begin
            dones++;
            check("done_valid_low", o_valid, 0);
            break;
         end
         case (ready_mode)
            0:       ready_now = 1'b1;
            1:       ready_now = (cyc % 3 == 1);
            default: ready_now = 1'($urandom_range(0, 1));
         endcase
         i_ready = ready_now;
         if (o_valid && ready_now) begin
            stalled = 0;
            if (exp_q.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("beat_addr", o_addr, e[WW-1:DW]);
               check("beat_data", o_data, e[DW-1:0]);
            end
            beats++;
            if (beats == abort_after) begin
               @(negedge clk);
               rst     = 1'b1;
               i_ready = 1'b0;
               start   = 1'b0;
               @(negedge clk);
               rst = 1'b0;
               check("rst_mid_valid", o_valid, 0);
               check("rst_mid_busy", busy, 0);
               check("rst_mid_done", done, 0);
               check("rst_mid_addr", o_addr, 0);
               exp_q.delete();
               return;
            end
         end else if (o_valid) begin
            stalled = 1;
            held_a  = o_addr;
            held_d  = o_data;
         end else begin
            stalled = 0;
         end
         if (cyc > 300) begin
            check("drain_timeout", 0, 1);
            break;
         end
      end
      start   = 1'b0;
      i_ready = 1'b0;
      check("beat_count", beats, n_exp);
      check("queue_empty", exp_q.size(), 0);
      check("done_count", dones, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
   endtask

   task automatic random_words(input int max_addr);
      for (int i = 0; i < DEPTH; i++)
         words[i] = {AW'($urandom_range(0, max_addr)), DW'($urandom)};
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; i_ready = 1'b0; i_PE = '0;
      repeat (2) @(negedge clk);
      check("reset_valid", o_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_addr", o_addr, 0);
      check("reset_data", o_data, 0);
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check("rst_beats_start", busy, 0);

      // Permutation {a, 7-a} for a = 7..0, always ready then with backpressure.
      for (int i = 0; i < DEPTH; i++) words[i] = {AW'(DEPTH - 1 - i), DW'(i)};
      run_test(0, -1, 0);
      for (int i = 0; i < DEPTH; i++) words[i] = {AW'(DEPTH - 1 - i), DW'(i)};
      run_test(1, -1, 0);

      // Duplicate address 5: seven copies of data 1, then data 6.
      for (int i = 0; i < DEPTH - 1; i++) words[i] = 6'b101001;
      words[DEPTH - 1] = 6'b101110;
      run_test(0, -1, 0);

      // Reset after three accepted beats, then a fresh sparse capture.
      random_words(DEPTH - 1);
      run_test(0, 3, 0);
      random_words(2);
      run_test(2, -1, 0);

      // Stray start pulses during capture and drain.
      random_words(DEPTH - 1);
      run_test(0, -1, 1);
      random_words(DEPTH - 1);
      run_test(1, -1, 1);

      for (int t = 0; t < 4; t++) begin
         random_words(DEPTH - 1);
         run_test(2, -1, t[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
